apb_sram_slave: RTL

//  APB4 completer (slave) fronting a word-organised on-chip SRAM; sits directly downstream of the
//  APB master on the same PCLK domain. Decodes PSEL/PENABLE phases, inserts programmable wait states
//  via PREADY, applies PSTRB byte-lane writes, returns PRDATA, flags PSLVERR on bad accesses.

---
 rtl/apb_sram_slave.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/apb_sram_slave.sv
// apb_sram_slave
//   APB4 completer in front of a word-organised on-chip SRAM, on the PCLK domain.
//   Each transfer takes a setup cycle and then WAIT_CYCLES wait states. PREADY is
//   registered and is high for exactly one access cycle. Writes honour the PSTRB
//   byte lanes. Misaligned or out-of-window addresses complete with PSLVERR.
//
//   Optional feature: define APB_SRAM_PROT_CHECK_EN to reject unprivileged
//   accesses (PPROT[0]=0) to word indices >= PROT_BASE. Such an access completes
//   with PSLVERR=1, the write is suppressed and PRDATA=0. When the macro is
//   undefined, PPROT is ignored.
//
// Ports
//   PCLK     in   1   clock, rising edge
//   PRESET   in   1   asynchronous reset, active-high
//   PSEL     in   1   completer select
//   PENABLE  in   1   access phase indicator
//   PWRITE   in   1   1 = write, 0 = read
//   PADDR    in   32  byte address
//   PWDATA   in   32  write data
//   PSTRB    in   4   byte-lane write strobes
//   PPROT    in   3   protection attributes, bit 0 = privileged
//   PRDATA   out  32  read data, nonzero only in the PREADY cycle of a good read
//   PREADY   out  1   transfer completion
//   PSLVERR  out  1   error response, only together with PREADY
//
// FSM
//   state  | meaning
//   IDLE   | waiting for a setup cycle (PSEL=1, PENABLE=0)
//   ACCESS | wait states counting down, then one PREADY cycle

module apb_sram_slave #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          PROT_BASE   = DEPTH / 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  input  logic [2:0]  PPROT,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pready_q, pready_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic [3:0]      strb_q, strb_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     rd_q;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     offset;
  logic [AW-1:0]   idx_in;
  logic            addr_err;
  logic            prot_err;
  logic            setup;
  logic            wr_en;
  logic            unused_ok;

  assign offset   = PADDR - BASE_ADDR;
  assign idx_in   = offset[AW+1:2];
  // BASE_ADDR is aligned to the window size, so any address below the base wraps
  // to a large offset. The explicit compare keeps that case obvious.
  assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR < BASE_ADDR) ||
                    (offset[31:AW+2] != '0);

`ifdef APB_SRAM_PROT_CHECK_EN
  assign prot_err  = !PPROT[0] && (32'(idx_in) >= 32'(PROT_BASE));
  assign unused_ok = ^{offset[1:0], PPROT[2:1]};
`else
  assign prot_err  = 1'b0;
  assign unused_ok = ^{offset[1:0], PPROT};
`endif

  assign setup = (state_q == IDLE) && PSEL && !PENABLE;
  assign wr_en = (state_q == ACCESS) && pready_q && write_q && !err_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      strb_q   <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      write_q  <= write_d;
      err_q    <= err_d;
      strb_q   <= strb_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pready_d = 1'b0;
    write_d  = write_q;
    err_d    = err_q;
    strb_d   = strb_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d  = ACCESS;
          cnt_d    = 4'(WAIT_CYCLES);
          // With zero wait states PREADY rises in the first access cycle.
          pready_d = (WAIT_CYCLES == 0);
          write_d  = PWRITE;
          err_d    = addr_err || prot_err;
          strb_d   = PSTRB;
          wdata_d  = PWDATA;
          idx_d    = idx_in;
        end
      end
      ACCESS: begin
        if (pready_q) begin
          state_d = IDLE;
        end else if (!PSEL) begin
          // The requester dropped the transfer: abort quietly, nothing committed.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          pready_d = (cnt_q == 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM has no reset. Reads are issued at the setup edge. Writes commit at the
  // PREADY edge, so a back-to-back read sees the freshly written word.
  always_ff @(posedge PCLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
    if (setup) rd_q <= mem[idx_in];
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pready_q && err_q;
  assign PRDATA  = (pready_q && !write_q && !err_q) ? rd_q : 32'h0;

endmodule
